// File: rtl/sqrt_iter_unit.sv
// Iterative integer square root: restoring digit-by-digit method, one root bit
// per clock, producing floor root, truncated remainder and optional rounding.
module sqrt_iter_unit #(
  parameter int IN_W  = 32,
  parameter int ROUND = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IN_W/2-1:0]     out_root,
  output logic [IN_W/2:0]       out_rem,
  output logic                  out_sat
);

  localparam int OUT_W = IN_W / 2;
  localparam int REM_W = OUT_W + 1;
  localparam int CAT_W = REM_W + 2;
  localparam int IT_W  = $clog2(OUT_W + 1);

  localparam logic [IT_W-1:0]  ITER_LAST = IT_W'(OUT_W);
  localparam logic [IT_W-1:0]  ITER_ONE  = IT_W'(1);
  localparam logic [OUT_W-1:0] ROOT_ONE  = OUT_W'(1);
  localparam logic [OUT_W-1:0] ROOT_ONES = {OUT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [IN_W-1:0]    r_rad;
  logic [REM_W-1:0]   r_rem;
  logic [OUT_W-1:0]   r_root;
  logic [IT_W-1:0]    r_iter;
  logic [OUT_W-1:0]   r_out_root;
  logic [REM_W-1:0]   r_out_rem;
  logic               r_out_sat;

  logic [CAT_W-1:0]   w_cat;
  logic [CAT_W-1:0]   w_sub;
  logic [CAT_W-1:0]   w_trial;
  logic               w_trial_neg;
  logic               w_round_up;
  logic [OUT_W-1:0]   w_final_root;
  logic               w_final_sat;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_root  = r_out_root;
  assign out_rem   = r_out_rem;
  assign out_sat   = r_out_sat;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_next_state = S_CALC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_iter == ITER_LAST) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_CALC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Trial subtraction, one extra bit wide so its sign bit decides the digit
  always_comb begin
    w_cat       = {r_rem, r_rad[IN_W-1 -: 2]};
    w_sub       = {1'b0, r_root, 2'b01};
    w_trial     = w_cat - w_sub;
    w_trial_neg = w_trial[CAT_W-1];
  end

  // Rounding: floor+1 is nearer exactly when in - r^2 > r
  always_comb begin
    w_round_up   = 1'b0;
    w_final_root = r_root;
    w_final_sat  = 1'b0;
    if (ROUND != 0) begin
      w_round_up = (r_rem > {1'b0, r_root});
      if (w_round_up && (r_root == ROOT_ONES)) begin
        w_final_root = ROOT_ONES;
        w_final_sat  = 1'b1;
      end else if (w_round_up) begin
        w_final_root = r_root + ROOT_ONE;
        w_final_sat  = 1'b0;
      end else begin
        w_final_root = r_root;
        w_final_sat  = 1'b0;
      end
    end else begin
      w_round_up   = 1'b0;
      w_final_root = r_root;
      w_final_sat  = 1'b0;
    end
  end

  // Iteration datapath and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rad      <= '0;
      r_rem      <= '0;
      r_root     <= '0;
      r_iter     <= '0;
      r_out_root <= '0;
      r_out_rem  <= '0;
      r_out_sat  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_rad  <= in_data;
            r_rem  <= '0;
            r_root <= '0;
            r_iter <= '0;
          end
        end
        S_CALC: begin
          if (r_iter != ITER_LAST) begin
            if (w_trial_neg) begin
              r_rem  <= w_cat[REM_W-1:0];
              r_root <= {r_root[OUT_W-2:0], 1'b0};
            end else begin
              r_rem  <= w_trial[REM_W-1:0];
              r_root <= {r_root[OUT_W-2:0], 1'b1};
            end
            r_rad  <= {r_rad[IN_W-3:0], 2'b00};
            r_iter <= r_iter + ITER_ONE;
          end else begin
            r_out_root <= w_final_root;
            r_out_rem  <= r_rem;
            r_out_sat  <= w_final_sat;
          end
        end
        default: begin
          r_iter <= r_iter;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_iter_unit.sv
// Directed and model-checked random bench for sqrt_iter_unit, running a
// ROUND=0 and a ROUND=1 instance side by side on the same stimulus.
module tb_sqrt_iter_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [15:0] out_root0, out_root1;
  logic [16:0] out_rem0, out_rem1;
  logic        out_sat0, out_sat1;

  int checks;
  int failures;

  sqrt_iter_unit #(.IN_W(32), .ROUND(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_root(out_root0), .out_rem(out_rem0), .out_sat(out_sat0)
  );

  sqrt_iter_unit #(.IN_W(32), .ROUND(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_root(out_root1), .out_rem(out_rem1), .out_sat(out_sat1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  // One transaction; stall = cycles of out_ready low in DONE, pulse = junk in_valid during CALC
  task automatic do_op(input logic [31:0] x, input logic [15:0] e_root0, input logic [16:0] e_rem,
                       input logic [15:0] e_root1, input logic e_sat1,
                       input int stall, input bit pulse, input bit chk_lat);
    int wait_cnt;
    int lat;
    wait_cnt = 0;
    while (!in_ready0 && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    check_val("in_ready_before", {63'd0, in_ready0}, 64'd1);
    @(negedge clk);
    in_data  = x;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid0 && lat < 40) begin
      if (pulse && lat == 3) begin
        in_data  = 32'h0000_0004;
        in_valid = 1'b1;
        #1;
        check_val("in_ready_calc", {63'd0, in_ready0}, 64'd0);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    if (chk_lat) check_val("latency", 64'(lat), 64'd17);
    else check_val("completed", {63'd0, out_valid0}, 64'd1);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      check_val("hold_valid", {63'd0, out_valid0}, 64'd1);
      check_val("hold_in_ready", {63'd0, in_ready0}, 64'd0);
      check_val("hold_root", {48'd0, out_root0}, {48'd0, e_root0});
      check_val("hold_rem", {47'd0, out_rem0}, {47'd0, e_rem});
    end
    check_val("root0", {48'd0, out_root0}, {48'd0, e_root0});
    check_val("rem0", {47'd0, out_rem0}, {47'd0, e_rem});
    check_val("sat0", {63'd0, out_sat0}, 64'd0);
    check_val("valid1", {63'd0, out_valid1}, 64'd1);
    check_val("root1", {48'd0, out_root1}, {48'd0, e_root1});
    check_val("rem1", {47'd0, out_rem1}, {47'd0, e_rem});
    check_val("sat1", {63'd0, out_sat1}, {63'd0, e_sat1});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val("post_hs_valid", {63'd0, out_valid0}, 64'd0);
    check_val("post_hs_in_ready", {63'd0, in_ready0}, 64'd1);
  endtask

  initial begin
    logic [31:0]     x;
    longint unsigned f;
    longint unsigned r;
    logic [15:0]     e1;
    logic            es;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    #22;
    check_val("rst_in_ready", {63'd0, in_ready0}, 64'd1);
    check_val("rst_out_valid", {63'd0, out_valid0}, 64'd0);
    check_val("rst_root", {48'd0, out_root0}, 64'd0);
    check_val("rst_rem", {47'd0, out_rem0}, 64'd0);
    check_val("rst_sat", {63'd0, out_sat1}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(32'd0,          16'd0,      17'd0,       16'd0,      1'b0, 0, 1'b0, 1'b1);
    do_op(32'hFFFF_FFFF,  16'hFFFF,   17'h1FFFE,   16'hFFFF,   1'b1, 0, 1'b0, 1'b1);
    do_op(32'd1000000,    16'd1000,   17'd0,       16'd1000,   1'b0, 0, 1'b0, 1'b1);
    do_op(32'd99,         16'd9,      17'd18,      16'd10,     1'b0, 5, 1'b1, 1'b1);
    do_op(32'd2,          16'd1,      17'd1,       16'd1,      1'b0, 0, 1'b0, 1'b1);
    do_op(32'd3,          16'd1,      17'd2,       16'd2,      1'b0, 1, 1'b0, 1'b1);
    do_op(32'hFFFE_0001,  16'hFFFF,   17'd0,       16'hFFFF,   1'b0, 0, 1'b0, 1'b1);

    // Reset in the middle of a calculation
    @(negedge clk);
    in_data  = 32'd12345678;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", {63'd0, out_valid0}, 64'd0);
    check_val("midrst_in_ready", {63'd0, in_ready0}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_val("midrst_no_result", {63'd0, out_valid0}, 64'd0);
    do_op(32'd144, 16'd12, 17'd0, 16'd12, 1'b0, 0, 1'b0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      x  = $urandom();
      if (i % 50 == 1) x = x >> (i % 31);
      f  = isqrt(longint'(x));
      r  = longint'(x) - f * f;
      if (r > f && f == 65535) begin e1 = 16'hFFFF; es = 1'b1; end
      else if (r > f) begin e1 = 16'(f + 1); es = 1'b0; end
      else begin e1 = 16'(f); es = 1'b0; end
      do_op(x, 16'(f), 17'(r), e1, es, int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
